// File: rtl/divisor_sequencial_4bits.sv
// Multi-cycle 4-bit unsigned restoring divider with a start/busy/done handshake.
// One shared subtrator_4bits performs a trial subtraction per clock; the
// quotient/remainder registers only change when a result is loaded or on reset.

// 4-bit ripple subtractor: diff = a - b - bin, bout set on underflow.
module subtrator_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [4:0] borrow;

    // Bit-serial borrow chain.
    always_comb begin
        borrow[0] = bin;
        for (int i = 0; i < 4; i++) begin
            diff[i]       = a[i] ^ b[i] ^ borrow[i];
            borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
        bout = borrow[4];
    end

endmodule

module divisor_sequencial_4bits #(
    parameter logic [3:0] ZERO_QUOTIENT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividendo,
    input  logic [3:0] divisor,
    output logic [3:0] quociente,
    output logic [3:0] resto,
    output logic       busy,
    output logic       done,
    output logic       div_zero
);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

    state_t     state_q, state_d;
    logic [3:0] r_q, r_d;       // partial remainder
    logic [3:0] q_q, q_d;       // dividend shifting out, quotient shifting in
    logic [3:0] d_q, d_d;       // captured divisor
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] rem_q, rem_d;
    logic       dz_q, dz_d;

    logic [4:0] s;
    logic [3:0] sub_diff;
    logic       sub_bout;
    logic       ok;
    logic [3:0] r_step;
    logic [3:0] q_step;

    subtrator_4bits u_sub (
        .a    (s[3:0]),
        .b    (d_q),
        .bin  (1'b0),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // s[4] set means the shifted remainder already exceeds any 4-bit divisor.
    always_comb begin
        s      = {r_q, q_q[3]};
        ok     = s[4] | ~sub_bout;
        r_step = ok ? sub_diff : s[3:0];
        q_step = {q_q[2:0], ok};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != 4'd0) begin
                        d_d     = divisor;
                        q_d     = dividendo;
                        r_d     = 4'd0;
                        cnt_d   = 2'd3;
                        dz_d    = 1'b0;
                        state_d = StIter;
                    end else begin
                        quo_d   = ZERO_QUOTIENT;
                        rem_d   = dividendo;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StIter: begin
                busy = 1'b1;
                r_d  = r_step;
                q_d  = q_step;
                if (cnt_q == 2'd0) begin
                    quo_d   = q_step;
                    rem_d   = r_step;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= 4'd0;
            q_q     <= 4'd0;
            d_q     <= 4'd0;
            cnt_q   <= 2'd0;
            quo_q   <= 4'd0;
            rem_q   <= 4'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign quociente = quo_q;
    assign resto     = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_divisor_sequencial_4bits.sv
// Directed bench for divisor_sequencial_4bits with a result scoreboard.
module tb_divisor_sequencial_4bits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividendo;
    logic [3:0] divisor;
    logic [3:0] quociente;
    logic [3:0] resto;
    logic       busy;
    logic       done;
    logic       div_zero;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    exp_t last;     // most recent expected result, must be held during ITER
    int   tests;
    int   fails;

    divisor_sequencial_4bits dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .quociente (quociente),
        .resto     (resto),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference divide result using the native operators.
    function automatic exp_t model(input logic [3:0] dd, input logic [3:0] dv);
        exp_t e;
        if (dv == 4'd0) begin
            e.q  = 4'hF;
            e.r  = dd;
            e.dz = 1'b1;
        end else begin
            e.q  = dd / dv;
            e.r  = dd % dv;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    // noise drives a competing 7/1 request throughout ITER and DONE.
    task automatic run_div(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                           input bit noise, input bit sweep);
        int   n;
        int   busy_cnt;
        exp_t e;
        start     = 1'b1;
        dividendo = dd;
        divisor   = dv;
        sb.push_back(model(dd, dv));
        @(posedge clk);
        @(negedge clk);
        start     = noise;
        dividendo = noise ? 4'd7 : $urandom_range(0, 15);
        divisor   = noise ? 4'd1 : $urandom_range(0, 15);
        n         = 0;
        busy_cnt  = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) begin
                busy_cnt++;
                if (!sweep) begin
                    check({tag, " held_q"}, {4'd0, quociente}, {4'd0, last.q});
                    check({tag, " held_r"}, {4'd0, resto}, {4'd0, last.r});
                end
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, " done"}, {7'd0, done}, 8'd1);
        check({tag, " latency"}, 8'(n), (dv == 4'd0) ? 8'd0 : 8'd4);
        check({tag, " busy_cycles"}, 8'(busy_cnt), (dv == 4'd0) ? 8'd0 : 8'd4);
        check({tag, " quociente"}, {4'd0, quociente}, {4'd0, e.q});
        check({tag, " resto"}, {4'd0, resto}, {4'd0, e.r});
        check({tag, " div_zero"}, {7'd0, div_zero}, {7'd0, e.dz});
        if (sweep && dv != 4'd0) begin
            check({tag, " invariant"}, 8'(quociente * dv + resto), {4'd0, dd});
            check({tag, " rem_lt_div"}, {7'd0, resto < dv}, 8'd1);
        end
        last = e;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_pulse"}, {7'd0, done}, 8'd0);
        check({tag, " idle_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        last      = '0;
        start     = 1'b0;
        dividendo = 4'd0;
        divisor   = 4'd0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset quociente", {4'd0, quociente}, 8'd0);
        check("reset resto", {4'd0, resto}, 8'd0);
        check("reset busy", {7'd0, busy}, 8'd0);
        check("reset done", {7'd0, done}, 8'd0);
        check("reset div_zero", {7'd0, div_zero}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("13/3", 4'd13, 4'd3, 1'b0, 1'b0);
        run_div("15/1", 4'd15, 4'd1, 1'b0, 1'b0);
        run_div("2/7", 4'd2, 4'd7, 1'b0, 1'b0);
        run_div("9/0", 4'd9, 4'd0, 1'b0, 1'b0);
        run_div("12/5 noisy", 4'd12, 4'd5, 1'b1, 1'b0);

        // Abort 14/3 mid-ITER with reset.
        start     = 1'b1;
        dividendo = 4'd14;
        divisor   = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort busy_before", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("abort quociente", {4'd0, quociente}, 8'd0);
        check("abort resto", {4'd0, resto}, 8'd0);
        check("abort div_zero", {7'd0, div_zero}, 8'd0);
        check("abort busy", {7'd0, busy}, 8'd0);
        check("abort done", {7'd0, done}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort no_done", {7'd0, done}, 8'd0);
        end
        rst_n = 1'b1;
        last  = '0;
        @(negedge clk);
        run_div("14/3", 4'd14, 4'd3, 1'b0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div("sweep", 4'(a), 4'(b), 1'b0, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
